mux_sched: RTL and testbench

MUX_SCHED -- requirements
Module: mux_sched

---
 rtl/mux_pkg.sv | 19 +
 rtl/mux_rr_pick.sv | 29 ++
 rtl/mux_sched.sv | 83 ++++++++
 tb/tb_mux_sched.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared encodings and elaboration helpers for the mux_sched channel multiplexer.
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// Rotating-priority search: first set bit of mask at or after ptr, modulo M.
// Purely combinational; the caller owns the pointer.
module mux_rr_pick #(
    parameter int M  = 4,
    parameter int SW = 2
) (
    input  logic [M-1:0]  mask,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] index,
    output logic          found
);

    logic [SW-1:0] w_cand;

    always_comb begin
        index  = '0;
        found  = 1'b0;
        w_cand = '0;
        // Walk from the farthest offset back towards ptr so the nearest enabled channel wins.
        for (int i = M - 1; i >= 0; i--) begin
            w_cand = ptr + SW'(i);
            if (mask[w_cand]) begin
                index = w_cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_sched.sv
// Channel multiplexer with direct or round-robin selection into a one-deep output register.
// Capture latency one cycle; out_valid && !out_ready stalls capture and freezes all state.
module mux_sched
    import mux_pkg::*;
#(
    parameter  int N  = 16,
    parameter  int M  = 4,
    localparam int SW = clog2(M)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           mode,
    input  logic [SW-1:0]  selecM,
    input  logic [M-1:0]   en_mask,
    input  logic [M*N-1:0] R,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [N-1:0]   Q,
    output logic [SW-1:0]  out_chan,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [N-1:0]  w_ch_dat [M];
    logic [SW-1:0] w_rr_index;
    logic          w_rr_found;
    logic          w_pick_ok;
    logic          w_capture;
    logic          w_consume;
    logic [SW-1:0] w_chan;

    logic [N-1:0]  r_q;
    logic [SW-1:0] r_chan;
    logic [SW-1:0] r_ptr;
    logic          r_valid;

    for (genvar k = 0; k < M; k++) begin : g_unpack
        assign w_ch_dat[k] = R[k*N +: N];
    end

    mux_rr_pick #(
        .M  (M),
        .SW (SW)
    ) u_pick (
        .mask  (en_mask),
        .ptr   (r_ptr),
        .index (w_rr_index),
        .found (w_rr_found)
    );

    // Scan mode with no enabled channel has nothing to offer, so it refuses the request.
    assign w_pick_ok = (mode == MODE_DIRECT) ? 1'b1 : w_rr_found;
    assign in_ready  = (!r_valid || out_ready) && w_pick_ok;
    assign w_capture = in_valid && in_ready;
    assign w_consume = r_valid && out_ready;
    assign w_chan    = (mode == MODE_DIRECT) ? selecM : w_rr_index;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q     <= '0;
            r_chan  <= '0;
            r_ptr   <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_capture) begin
                r_q     <= w_ch_dat[w_chan];
                r_chan  <= w_chan;
                r_valid <= 1'b1;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end
            // Pointer advances past the granted channel only on scan grants; M is a power of two so it wraps naturally.
            if (w_capture && (mode == MODE_SCAN)) begin
                r_ptr <= w_rr_index + SW'(1);
            end
        end
    end

    assign Q         = r_q;
    assign out_chan  = r_chan;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_sched.sv
// Table-driven and scenario checks for mux_sched with a capture scoreboard.
module tb_mux_sched;

    localparam int N  = 16;
    localparam int M  = 4;
    localparam int SW = 2;

    logic           clk;
    logic           reset;
    logic           mode;
    logic [SW-1:0]  selecM;
    logic [M-1:0]   en_mask;
    logic [M*N-1:0] R;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   Q;
    logic [SW-1:0]  out_chan;
    logic           out_valid;
    logic           out_ready;

    logic [N-1:0]   ch_dat [M];

    typedef struct {
        logic          mode;
        logic [SW-1:0] sel;
        logic [M-1:0]  mask;
        logic          iv;
        logic          ordy;
        logic          exp_ir;
        logic          exp_ov;
        logic [SW-1:0] exp_ch;
    } vec_t;

    typedef struct {
        logic [N-1:0]  q;
        logic [SW-1:0] ch;
    } samp_t;

    samp_t         sb [$];
    vec_t          tbl [$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [N-1:0]  last_q;
    logic [SW-1:0] last_ch;

    assign R = {ch_dat[3], ch_dat[2], ch_dat[1], ch_dat[0]};

    mux_sched #(
        .N (N),
        .M (M)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .selecM    (selecM),
        .en_mask   (en_mask),
        .R         (R),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Q         (Q),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic md, input logic [SW-1:0] sel, input logic [M-1:0] mask,
                                input logic iv, input logic ordy, input logic eir, input logic eov,
                                input logic [SW-1:0] ech);
        vec_t v;
        v.mode = md;  v.sel = sel;   v.mask = mask;  v.iv = iv;
        v.ordy = ordy; v.exp_ir = eir; v.exp_ov = eov; v.exp_ch = ech;
        return v;
    endfunction

    // One cycle: drive, check in_ready, push expected capture, clock, pop and compare outputs.
    task automatic run_vec(input string nm, input vec_t v);
        samp_t s;
        bit    pushed;
        mode      = v.mode;
        selecM    = v.sel;
        en_mask   = v.mask;
        in_valid  = v.iv;
        out_ready = v.ordy;
        #1;
        chk({nm, "/in_ready"}, 32'(in_ready), 32'(v.exp_ir));
        pushed = v.iv && v.exp_ir;
        if (pushed) begin
            s.q  = ch_dat[v.exp_ch];
            s.ch = v.exp_ch;
            sb.push_back(s);
        end
        @(posedge clk);
        #1;
        chk({nm, "/out_valid"}, 32'(out_valid), 32'(v.exp_ov));
        if (pushed && sb.size() > 0) begin
            s       = sb.pop_front();
            last_q  = s.q;
            last_ch = s.ch;
        end
        chk({nm, "/Q"}, 32'(Q), 32'(last_q));
        chk({nm, "/out_chan"}, 32'(out_chan), 32'(last_ch));
    endtask

    task automatic do_reset(input string nm, input logic md, input logic [M-1:0] mk_in,
                            input logic iv, input logic ordy);
        reset     = 1'b1;
        mode      = md;
        selecM    = '0;
        en_mask   = mk_in;
        in_valid  = iv;
        out_ready = ordy;
        @(posedge clk);
        #1;
        chk({nm, "/out_valid"}, 32'(out_valid), 32'd0);
        chk({nm, "/Q"}, 32'(Q), 32'd0);
        chk({nm, "/out_chan"}, 32'(out_chan), 32'd0);
        chk({nm, "/in_ready"}, 32'(in_ready), (md == 1'b0) ? 32'd1 : 32'(|mk_in));
        reset = 1'b0;
        sb.delete();
        last_q  = '0;
        last_ch = '0;
    endtask

    initial begin
        ch_dat[0] = 16'h0123;
        ch_dat[1] = 16'h5A5A;
        ch_dat[2] = 16'hBEEF;
        ch_dat[3] = 16'hC0DE;
        last_q    = '0;
        last_ch   = '0;

        //                md    sel    mask     iv ordy ir ov ch
        tbl.push_back(mk(1'b0, 2'd2, 4'b0000, 1, 1, 1, 1, 2'd2));
        tbl.push_back(mk(1'b1, 2'd0, 4'b1111, 1, 1, 1, 1, 2'd0));
        tbl.push_back(mk(1'b1, 2'd0, 4'b1111, 1, 1, 1, 1, 2'd1));
        tbl.push_back(mk(1'b1, 2'd0, 4'b1111, 1, 1, 1, 1, 2'd2));
        tbl.push_back(mk(1'b1, 2'd0, 4'b1111, 1, 1, 1, 1, 2'd3));
        tbl.push_back(mk(1'b1, 2'd0, 4'b1111, 1, 1, 1, 1, 2'd0));
        tbl.push_back(mk(1'b1, 2'd0, 4'b1111, 1, 1, 1, 1, 2'd1));
        tbl.push_back(mk(1'b1, 2'd0, 4'b1111, 1, 1, 1, 1, 2'd2));
        tbl.push_back(mk(1'b1, 2'd0, 4'b1111, 1, 1, 1, 1, 2'd3));
        tbl.push_back(mk(1'b1, 2'd0, 4'b1010, 1, 1, 1, 1, 2'd1));
        tbl.push_back(mk(1'b1, 2'd0, 4'b1010, 1, 1, 1, 1, 2'd3));
        tbl.push_back(mk(1'b1, 2'd0, 4'b1010, 1, 1, 1, 1, 2'd1));
        tbl.push_back(mk(1'b1, 2'd0, 4'b0000, 1, 1, 0, 0, 2'd0));
        tbl.push_back(mk(1'b1, 2'd0, 4'b0000, 1, 0, 0, 0, 2'd0));
        tbl.push_back(mk(1'b0, 2'd1, 4'b0000, 0, 0, 1, 0, 2'd0));
        tbl.push_back(mk(1'b0, 2'd3, 4'b0000, 1, 0, 1, 1, 2'd3));
        tbl.push_back(mk(1'b0, 2'd0, 4'b0000, 1, 0, 0, 1, 2'd0));
        tbl.push_back(mk(1'b1, 2'd0, 4'b1111, 1, 0, 0, 1, 2'd0));
        tbl.push_back(mk(1'b1, 2'd0, 4'b1111, 1, 1, 1, 1, 2'd2));
        tbl.push_back(mk(1'b0, 2'd0, 4'b1111, 1, 1, 1, 1, 2'd0));
        tbl.push_back(mk(1'b1, 2'd0, 4'b1111, 1, 1, 1, 1, 2'd3));
        tbl.push_back(mk(1'b1, 2'd0, 4'b0100, 1, 1, 1, 1, 2'd2));
        tbl.push_back(mk(1'b1, 2'd0, 4'b0001, 1, 1, 1, 1, 2'd0));
        tbl.push_back(mk(1'b1, 2'd0, 4'b1111, 0, 1, 1, 0, 2'd0));
        tbl.push_back(mk(1'b1, 2'd0, 4'b1111, 0, 0, 1, 0, 2'd0));

        // Scan mode with nothing enabled keeps in_ready low even while held in reset.
        do_reset("rst0", 1'b1, 4'b0000, 1'b1, 1'b1);

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec($sformatf("v%0d", i), tbl[i]);
        end

        // Backpressure: data and select churn must not disturb the held sample.
        run_vec("bp_cap", mk(1'b0, 2'd1, 4'b0000, 1, 0, 1, 1, 2'd1));
        for (int i = 0; i < 3; i++) begin
            ch_dat[i] = 16'(($urandom & 32'hFFFF) ^ 32'h0000_8001);
            ch_dat[3] = ch_dat[3] + 16'h0111;
            run_vec($sformatf("bp_hold%0d", i), mk(1'b0, 2'(i), 4'b0000, 1, 0, 0, 1, 2'd0));
        end
        run_vec("bp_release", mk(1'b0, 2'd2, 4'b0000, 1, 1, 1, 1, 2'd2));

        // Reset during backpressure with ptr=2 wins over a same-cycle capture and consume.
        do_reset("rst1", 1'b0, 4'b0000, 1'b0, 1'b0);
        run_vec("pr_a", mk(1'b1, 2'd0, 4'b1111, 1, 1, 1, 1, 2'd0));
        run_vec("pr_b", mk(1'b1, 2'd0, 4'b1111, 1, 1, 1, 1, 2'd1));
        run_vec("pr_hold", mk(1'b1, 2'd0, 4'b1111, 0, 0, 0, 1, 2'd0));
        do_reset("rst2", 1'b1, 4'b1111, 1'b1, 1'b1);
        run_vec("post_rst", mk(1'b1, 2'd0, 4'b1111, 1, 0, 1, 1, 2'd0));

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
